// File: rtl/cdb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cdb_arbiter_pkg
//  Brief    : Functional-unit indices and default priority map for the CDB.
//  Revision : 1.0
// ============================================================================
package cdb_arbiter_pkg;

    localparam int NUM_FU = 4;

    localparam int FU_ALU = 0;
    localparam int FU_BR  = 1;
    localparam int FU_LSU = 2;
    localparam int FU_MDU = 3;

    // Only the ALU is high priority; long-latency units rely on starvation promotion.
    localparam logic [NUM_FU-1:0] HIPRI_MASK_DEFAULT = 4'b0001;

endpackage : cdb_arbiter_pkg
`default_nettype wire

// File: rtl/uarch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uarch_pkg
//  Brief    : Core-wide micro-architecture types shared by execute-stage blocks.
//  Revision : 1.0
// ============================================================================
package uarch_pkg;

    localparam int TAG_W = 6;
    localparam int XLEN  = 32;

    typedef struct packed {
        logic             is_valid;
        logic [TAG_W-1:0] dest_tag;
        logic [XLEN-1:0]  result;
    } writeback_packet_t;

endpackage : uarch_pkg
`default_nettype wire

// File: rtl/cdb_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
//  Module   : rr_picker
//  Brief    : Round-robin first-found picker scanning upward from a start index.
//  Revision : 1.0
// ============================================================================
module rr_picker #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_start,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_valid
);

    localparam logic [IW:0] c_n = (IW+1)'(N);

    logic [IW:0] w_pos;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_pos   = '0;
        for (int k = 0; k < N; k++) begin
            w_pos = {1'b0, i_start} + (IW+1)'(k);
            if (w_pos >= c_n) begin
                w_pos = w_pos - c_n;
            end
            if (!o_valid && i_req[w_pos[IW-1:0]]) begin
                o_valid               = 1'b1;
                o_gnt[w_pos[IW-1:0]]  = 1'b1;
                o_idx                 = w_pos[IW-1:0];
            end
        end
    end

endmodule : rr_picker
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : cdb_arbiter
//  Brief    : Single-port CDB arbiter: two priority classes, round-robin within
//             each, starvation promotion, registered broadcast.
//  Revision : 1.0
// ============================================================================
module cdb_arbiter
    import uarch_pkg::*;
    import cdb_arbiter_pkg::*;
#(
    parameter int                 NUM_REQ      = NUM_FU,
    parameter logic [NUM_REQ-1:0] HIPRI_MASK   = NUM_REQ'(HIPRI_MASK_DEFAULT),
    parameter int                 STARVE_LIMIT = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  writeback_packet_t fu_result [NUM_REQ],
    output logic [NUM_REQ-1:0] fu_gnt,
    output writeback_packet_t cdb_out
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    localparam logic [CW-1:0] c_starve = CW'(STARVE_LIMIT);
    localparam logic [IW-1:0] c_last   = IW'(NUM_REQ - 1);

    logic [NUM_REQ-1:0] w_req;
    logic [NUM_REQ-1:0] w_eff_hi;
    logic [NUM_REQ-1:0] w_hi_req;

    logic [NUM_REQ-1:0] w_hi_gnt;
    logic [NUM_REQ-1:0] w_lo_gnt;
    logic [IW-1:0]      w_hi_idx;
    logic [IW-1:0]      w_lo_idx;
    logic               w_hi_valid;
    logic               w_lo_valid;

    logic               w_use_hi;
    logic               w_any;
    logic [IW-1:0]      w_gnt_idx;
    logic [IW-1:0]      w_next_ptr;

    logic [IW-1:0]      r_hi_ptr;
    logic [IW-1:0]      r_lo_ptr;
    logic [CW-1:0]      r_wait_cnt [NUM_REQ];
    writeback_packet_t  r_cdb;

    // Gating with rst keeps the grant quiet during reset without waiting for an edge.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
        assign w_req[i]    = fu_result[i].is_valid & ~flush & ~rst;
        assign w_eff_hi[i] = HIPRI_MASK[i] | (r_wait_cnt[i] == c_starve);
    end

    assign w_hi_req = w_req & w_eff_hi;

    rr_picker #(.N(NUM_REQ)) u_hi_pick (
        .i_req   (w_hi_req),
        .i_start (r_hi_ptr),
        .o_gnt   (w_hi_gnt),
        .o_idx   (w_hi_idx),
        .o_valid (w_hi_valid)
    );

    rr_picker #(.N(NUM_REQ)) u_lo_pick (
        .i_req   (w_req),
        .i_start (r_lo_ptr),
        .o_gnt   (w_lo_gnt),
        .o_idx   (w_lo_idx),
        .o_valid (w_lo_valid)
    );

    assign w_use_hi   = w_hi_valid;
    assign w_any      = w_lo_valid;
    assign fu_gnt     = w_use_hi ? w_hi_gnt : w_lo_gnt;
    assign w_gnt_idx  = w_use_hi ? w_hi_idx : w_lo_idx;
    assign w_next_ptr = (w_gnt_idx == c_last) ? '0 : w_gnt_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi_ptr <= '0;
            r_lo_ptr <= '0;
            r_cdb    <= '0;
        end else begin
            r_cdb <= w_any ? fu_result[w_gnt_idx] : '0;
            // A promoted low-priority winner came from the high scan, so it moves hi_ptr.
            if (w_use_hi) begin
                r_hi_ptr <= w_next_ptr;
            end else if (w_any) begin
                r_lo_ptr <= w_next_ptr;
            end
        end
    end

    // High-priority counters are held at zero and reduce to constants.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (HIPRI_MASK[i] || rst || flush || !w_req[i] || fu_gnt[i]) begin
                r_wait_cnt[i] <= '0;
            end else if (r_wait_cnt[i] != c_starve) begin
                r_wait_cnt[i] <= r_wait_cnt[i] + 1'b1;
            end
        end
    end

    assign cdb_out = r_cdb;

    a_gnt_onehot0 : assert property (@(posedge clk) $onehot0(fu_gnt));
    a_gnt_has_req : assert property (@(posedge clk) (fu_gnt & ~w_req) == '0);

endmodule : cdb_arbiter
`default_nettype wire
